// File: rtl/exc_ctrl.sv
// exc_ctrl: precise exception initiator feeding CP0.
// Tags ride ID->EX->MEM; MEM decides, then a fixed flush window.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic        if_adel,
  input  logic        id_ri,
  input  logic        id_sys,
  input  logic        id_bp,
  input  logic        id_eret,
  input  logic        id_bd,
  input  logic        ex_ov,
  input  logic        mem_adel,
  input  logic        mem_ades,
  input  logic [31:0] mem_vaddr,
  input  logic        interupt,
  input  logic        cp0_exl,
  input  logic [31:0] return_addr,
  output logic        execption,
  output logic        ret,
  output logic [4:0]  exc_code,
  output logic [31:0] epc,
  output logic        bd,
  output logic [31:0] bad_vaddr,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic        adel;
  } id_tag_t;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic        bd;
    logic        adel;
    logic        ri;
    logic        sys;
    logic        bp;
    logic        eret;
  } ex_tag_t;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic        bd;
    logic        adel;
    logic        ri;
    logic        sys;
    logic        bp;
    logic        eret;
    logic        ov;
  } mem_tag_t;

  typedef enum logic {IDLE, FLUSH} state_t;

  id_tag_t  id_q;
  ex_tag_t  ex_q;
  mem_tag_t mem_q;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic        irq;
  logic        decide;
  logic        fault;
  logic        take;
  logic        eret_go;
  logic        ld_bva;
  logic [4:0]  code;
  logic [31:0] bva;

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q  <= '0;
      ex_q  <= '0;
      mem_q <= '0;
    end else if (flush) begin
      id_q.v  <= 1'b0;
      ex_q.v  <= 1'b0;
      mem_q.v <= 1'b0;
    end else if (!stall) begin
      id_q.v    <= if_valid;
      id_q.pc   <= if_pc;
      id_q.adel <= if_adel;
      ex_q.v    <= id_q.v;
      ex_q.pc   <= id_q.pc;
      ex_q.adel <= id_q.adel;
      ex_q.bd   <= id_bd;
      ex_q.ri   <= id_ri;
      ex_q.sys  <= id_sys;
      ex_q.bp   <= id_bp;
      ex_q.eret <= id_eret;
      mem_q.v    <= ex_q.v;
      mem_q.pc   <= ex_q.pc;
      mem_q.bd   <= ex_q.bd;
      mem_q.adel <= ex_q.adel;
      mem_q.ri   <= ex_q.ri;
      mem_q.sys  <= ex_q.sys;
      mem_q.bp   <= ex_q.bp;
      mem_q.eret <= ex_q.eret;
      mem_q.ov   <= ex_ov;
    end
  end

  // Cause priority at the commit point
  always_comb begin
    irq    = interupt & ~cp0_exl;
    decide = mem_q.v & (state_q == IDLE);
    fault  = 1'b1;
    code   = 5'h00;
    ld_bva = 1'b0;
    bva    = mem_vaddr;
    if (irq) begin
      code = 5'h00;
    end else if (mem_q.adel) begin
      code   = 5'h04;
      ld_bva = 1'b1;
      bva    = mem_q.pc;
    end else if (mem_q.ri) begin
      code = 5'h0A;
    end else if (mem_q.ov) begin
      code = 5'h0C;
    end else if (mem_q.sys) begin
      code = 5'h08;
    end else if (mem_q.bp) begin
      code = 5'h09;
    end else if (mem_adel) begin
      code   = 5'h04;
      ld_bva = 1'b1;
    end else if (mem_ades) begin
      code   = 5'h05;
      ld_bva = 1'b1;
    end else begin
      fault = 1'b0;
    end
    take    = decide & fault;
    eret_go = decide & ~fault & mem_q.eret;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (take | eret_go) begin
          state_d = FLUSH;
          cnt_d   = CNT_INIT;
        end
      end
      FLUSH: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else cnt_d = cnt_q - 4'd1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      execption      <= 1'b0;
      ret            <= 1'b0;
      exc_code       <= 5'h00;
      epc            <= 32'h0;
      bd             <= 1'b0;
      bad_vaddr      <= 32'h0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
    end else begin
      execption      <= take;
      ret            <= eret_go;
      redirect_valid <= take | eret_go;
      flush          <= (state_d == FLUSH);
      if (take) begin
        exc_code    <= code;
        epc         <= mem_q.bd ? mem_q.pc - 32'd4 : mem_q.pc;
        bd          <= mem_q.bd;
        redirect_pc <= EXC_VECTOR;
        if (ld_bva) bad_vaddr <= bva;
      end else if (eret_go) begin
        redirect_pc <= return_addr;
      end
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed and random checks of exc_ctrl
// against an instruction-level reference model.
module tb_exc_ctrl;

  localparam logic [31:0] VEC = 32'hBFC00380;
  localparam int FLUSH_N = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        if_adel;
  logic        id_ri, id_sys, id_bp, id_eret, id_bd;
  logic        ex_ov;
  logic        mem_adel, mem_ades;
  logic [31:0] mem_vaddr;
  logic        interupt, cp0_exl;
  logic [31:0] return_addr;
  logic        execption, ret, bd, flush, redirect_valid;
  logic [4:0]  exc_code;
  logic [31:0] epc, bad_vaddr, redirect_pc;

  exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FLUSH_N)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .if_valid(if_valid), .if_pc(if_pc), .if_adel(if_adel),
    .id_ri(id_ri), .id_sys(id_sys), .id_bp(id_bp),
    .id_eret(id_eret), .id_bd(id_bd), .ex_ov(ex_ov),
    .mem_adel(mem_adel), .mem_ades(mem_ades),
    .mem_vaddr(mem_vaddr), .interupt(interupt),
    .cp0_exl(cp0_exl), .return_addr(return_addr),
    .execption(execption), .ret(ret), .exc_code(exc_code),
    .epc(epc), .bd(bd), .bad_vaddr(bad_vaddr), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One record per in-flight instruction; slot 0=ID, 1=EX, 2=MEM
  typedef struct {
    bit        v;
    bit [31:0] pc;
    bit        adel, bd, ri, sys, bp, eret, ov;
  } rec_t;

  rec_t pipe[3];
  int   flush_left;
  bit        e_exc, e_ret, e_bd, e_flush, e_rv;
  bit [4:0]  e_code;
  bit [31:0] e_epc, e_bva, e_rpc;

  function automatic rec_t empty_rec();
    rec_t r;
    r = '{v:0, pc:0, adel:0, bd:0, ri:0, sys:0, bp:0, eret:0, ov:0};
    return r;
  endfunction

  task automatic model_step();
    int cause;
    bit busy;
    rec_t m;
    if (rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = empty_rec();
      flush_left = 0;
      {e_exc, e_ret, e_bd, e_flush, e_rv} = '0;
      e_code = 0; e_epc = 0; e_bva = 0; e_rpc = 0;
      return;
    end
    busy = flush_left > 0;
    m = pipe[2];
    e_exc = 0; e_ret = 0; e_rv = 0;
    if (busy) flush_left--;
    else if (m.v) begin
      cause = -1;
      if (interupt && !cp0_exl) cause = 0;
      else if (m.adel) begin cause = 4; e_bva = m.pc; end
      else if (m.ri) cause = 10;
      else if (m.ov) cause = 12;
      else if (m.sys) cause = 8;
      else if (m.bp) cause = 9;
      else if (mem_adel) begin cause = 4; e_bva = mem_vaddr; end
      else if (mem_ades) begin cause = 5; e_bva = mem_vaddr; end
      if (cause >= 0) begin
        e_exc = 1; e_rv = 1;
        e_code = 5'(cause);
        e_epc = m.bd ? m.pc - 32'd4 : m.pc;
        e_bd = m.bd;
        e_rpc = VEC;
        flush_left = FLUSH_N;
      end else if (m.eret) begin
        e_ret = 1; e_rv = 1;
        e_rpc = return_addr;
        flush_left = FLUSH_N;
      end
    end
    e_flush = flush_left > 0;
    if (busy) begin
      for (int i = 0; i < 3; i++) pipe[i].v = 0;
    end else if (!stall) begin
      pipe[2] = pipe[1];
      pipe[2].ov = ex_ov;
      pipe[1] = pipe[0];
      pipe[1].bd = id_bd;
      pipe[1].ri = id_ri;
      pipe[1].sys = id_sys;
      pipe[1].bp = id_bp;
      pipe[1].eret = id_eret;
      pipe[0] = empty_rec();
      pipe[0].v = if_valid;
      pipe[0].pc = if_pc;
      pipe[0].adel = if_adel;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("execption", execption, e_exc);
    check("ret", ret, e_ret);
    check("redirect_valid", redirect_valid, e_rv);
    check("flush", flush, e_flush);
    check("exc_code", exc_code, e_code);
    check("epc", epc, e_epc);
    check("bd", bd, e_bd);
    check("bad_vaddr", bad_vaddr, e_bva);
    check("redirect_pc", redirect_pc, e_rpc);
  endtask

  task automatic clear();
    rst = 0; stall = 0; if_valid = 0; if_pc = 0; if_adel = 0;
    id_ri = 0; id_sys = 0; id_bp = 0; id_eret = 0; id_bd = 0;
    ex_ov = 0; mem_adel = 0; mem_ades = 0; mem_vaddr = 0;
    interupt = 0; cp0_exl = 0; return_addr = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) begin clear(); step(); end
  endtask

  task automatic inject(input logic [31:0] pc, input bit adel, ibd,
                        input bit ri, sys, bp, er, ov, madel, mades,
                        input logic [31:0] va, ra,
                        input bit irq, exl, stl);
    clear(); if_valid = 1; if_pc = pc; if_adel = adel; step();
    clear(); id_ri = ri; id_sys = sys; id_bp = bp;
    id_eret = er; id_bd = ibd; step();
    clear(); ex_ov = ov; step();
    clear(); mem_adel = madel; mem_ades = mades; mem_vaddr = va;
    return_addr = ra; interupt = irq; cp0_exl = exl; stall = stl;
    step();
  endtask

  initial begin
    clear();
    rst = 1;
    step();
    step();
    check("rst_flush", flush, 0);
    check("rst_redirect_pc", redirect_pc, 0);

    // Syscall, flush window
    inject(32'h80000100, 0,0, 0,1,0,0,0, 0,0, 0, 0, 0,0,0);
    check("sys_exc", execption, 1);
    check("sys_code", exc_code, 5'h08);
    check("sys_epc", epc, 32'h80000100);
    check("sys_rpc", redirect_pc, 32'hBFC00380);
    clear(); step();
    check("sys_flush1", flush, 1);
    check("sys_exc_once", execption, 0);
    clear(); step();
    check("sys_flush_end", flush, 0);
    drain();

    // Overflow in a delay slot
    inject(32'h80000204, 0,1, 0,0,0,0,1, 0,0, 0, 0, 0,0,0);
    check("ov_code", exc_code, 5'h0C);
    check("ov_bd", bd, 1);
    check("ov_epc", epc, 32'h80000200);
    drain();

    // Fetch AdEL beats RI
    inject(32'h80000003, 1,0, 1,0,0,0,0, 0,0, 0, 0, 0,0,0);
    check("adel_code", exc_code, 5'h04);
    check("adel_bva", bad_vaddr, 32'h80000003);
    drain();

    // Misaligned store
    inject(32'h80000300, 0,0, 0,0,0,0,0, 0,1, 32'h00400002, 0, 0,0,0);
    check("ades_code", exc_code, 5'h05);
    check("ades_bva", bad_vaddr, 32'h00400002);
    drain();

    // Eret
    inject(32'h80000400, 0,0, 0,0,0,1,0, 0,0, 0, 32'h80001000, 0,0,0);
    check("eret_ret", ret, 1);
    check("eret_exc", execption, 0);
    check("eret_rpc", redirect_pc, 32'h80001000);
    drain();

    // Interrupt while stalled with MEM valid
    inject(32'h80000500, 0,0, 0,0,0,0,0, 0,0, 0, 0, 1,0,1);
    check("irq_exc", execption, 1);
    check("irq_code", exc_code, 5'h00);
    for (int i = 0; i < 3; i++) begin
      clear(); interupt = 1; stall = 1; step();
      check("irq_not_retaken", execption, 0);
    end
    drain();

    // Interrupt masked by EXL
    inject(32'h80000600, 0,0, 0,0,0,0,0, 0,0, 0, 0, 1,1,0);
    check("exl_mask", execption, 0);
    drain();

    // Reset in the middle of the flush window
    inject(32'h80000700, 0,0, 0,0,1,0,0, 0,0, 0, 0, 0,0,0);
    check("bp_code", exc_code, 5'h09);
    clear(); step();
    clear(); rst = 1; step();
    check("rst_mid_flush", flush, 0);
    check("rst_mid_code", exc_code, 0);
    clear(); step();

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      stall = ($urandom_range(0, 4) == 0);
      if_valid = ($urandom_range(0, 9) < 8);
      if_pc = ($urandom_range(0, 15) == 0) ? $urandom
                                           : ($urandom & ~32'h3);
      if_adel = ($urandom_range(0, 19) == 0);
      id_ri = ($urandom_range(0, 19) == 0);
      id_sys = ($urandom_range(0, 19) == 0);
      id_bp = ($urandom_range(0, 19) == 0);
      id_eret = ($urandom_range(0, 14) == 0);
      id_bd = ($urandom_range(0, 3) == 0);
      ex_ov = ($urandom_range(0, 19) == 0);
      mem_adel = ($urandom_range(0, 19) == 0);
      mem_ades = ($urandom_range(0, 19) == 0);
      mem_vaddr = $urandom;
      interupt = ($urandom_range(0, 11) == 0);
      cp0_exl = ($urandom_range(0, 1) == 0);
      return_addr = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Pipeline-side exception initiator that drives the CP0 register file's exception and return inputs.
- Carries per-instruction exception tags from ID through MEM and takes precise exceptions at MEM, the commit point.
- Samples CP0's interrupt request, prioritises causes and pulses the exception or return request to CP0.
- Issues pipeline flush and PC redirect, then holds a fixed flush window before accepting new events.

Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect target for every exception and interrupt.
- FLUSH_CYCLES, 2, cycles flush stays high after a take (>=1); counter width is 4 bits.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- stall  in  1  pipeline stall; all tag registers hold.
- if_valid  in  1  valid fetched instruction entering ID.
- if_pc  in  32  PC of that instruction.
- if_adel  in  1  fetch address misaligned.
- id_ri  in  1  reserved instruction, applies to the instruction in ID.
- id_sys  in  1  syscall, applies to the instruction in ID.
- id_bp  in  1  break, applies to the instruction in ID.
- id_eret  in  1  eret, applies to the instruction in ID.
- id_bd  in  1  instruction in ID is in a delay slot.
- ex_ov  in  1  arithmetic overflow in EX.
- mem_adel  in  1  load misaligned in MEM.
- mem_ades  in  1  store misaligned in MEM.
- mem_vaddr  in  32  data address in MEM.
- interupt  in  1  interrupt request from CP0.
- cp0_exl  in  1  CP0 Status.EXL.
- return_addr  in  32  EPC from CP0.
- execption  out  1  one-cycle exception request to CP0.
- return  out  1  one-cycle eret request to CP0.
- exc_code  out  5  Cause.ExcCode.
- epc  out  32  EPC value.
- bd  out  1  delay-slot flag.
- bad_vaddr  out  32  BadVAddr value.
- flush  out  1  kill all in-flight instructions.
- redirect_valid  out  1  one-cycle PC redirect.
- redirect_pc  out  32  redirect target.

Behaviour:
- Reset: all tag valids=0, FSM=IDLE, counter=0.
- Reset values of the outputs: execption=0, return=0, exc_code=0, epc=0, bd=0, bad_vaddr=0, flush=0, redirect_valid=0, redirect_pc=0.
- All outputs are registered and asserted the cycle after the MEM decision.
- Tag pipeline: ID tag {v,pc,adel}, EX tag {v,pc,bd,adel,ri,sys,bp,eret}, MEM tag {EX tag + ov}.
- When stall=0, each tag loads from the previous stage, and the ID/EX inputs are ORed into the tag as it advances.
- When stall=1, all tags hold. flush=1 clears every valid and overrides stall.
- MEM decision is evaluated when MEM.v=1 and FSM=IDLE. Causes in priority order:
  - interrupt (interupt & ~cp0_exl): code 0x00.
  - fetch AdEL: code 0x04, bad_vaddr=pc.
  - RI: code 0x0A.
  - Ov: code 0x0C.
  - Sys: code 0x08.
  - Bp: code 0x09.
  - data AdEL: code 0x04, bad_vaddr=mem_vaddr.
  - AdES: code 0x05, bad_vaddr=mem_vaddr.
- bad_vaddr keeps its previous value for causes that do not load it.
- Exception taken: execption=1 and redirect_valid=1 for one cycle; redirect_pc=EXC_VECTOR.
  - epc = bd ? pc-4 : pc, modulo 2^32.
  - bd=tag.bd.
- Eret with no higher cause: return=1 and redirect_valid=1 for one cycle; redirect_pc=return_addr sampled at decision; execption stays 0.
- Eret together with any fault: the fault wins and return stays 0.
- execption and return are never high together.
- FSM:
  - IDLE -> FLUSH on take or eret: flush=1, counter=FLUSH_CYCLES-1.
  - FLUSH: flush stays 1; counter decrements each cycle; at 0 go to IDLE with flush=0.
  - FLUSH ignores MEM tags and interrupts.
  - stall has no effect on FLUSH.
- Interrupt with MEM.v=0: not taken; wait for the next valid MEM instruction.
- Interrupt with cp0_exl=1: masked.
- rst mid-FLUSH: return to IDLE immediately; all outputs return to reset values.

Test Plan:
- Sys at pc 0x80000100, bd=0 -> execption=1, exc_code=0x08, epc=0x80000100, redirect_pc=0xBFC00380; flush high exactly 2 cycles.
- Ov in delay slot at pc 0x80000204 -> exc_code=0x0C, bd=1, epc=0x80000200.
- Same instruction with fetch AdEL (pc 0x80000003) and RI -> exc_code=0x04, bad_vaddr=0x80000003.
- Store with mem_vaddr 0x00400002 -> exc_code=0x05, bad_vaddr=0x00400002.
- Eret with return_addr 0x80001000 -> return=1, execption=0, redirect_pc=0x80001000.
- interupt=1, cp0_exl=0, pipeline stalled with MEM valid: stall=1 does not block the decision -> code 0x00 taken once, not re-taken during FLUSH.
- interupt=1 with cp0_exl=1 -> no take.
- rst asserted mid-FLUSH -> flush=0 next cycle.
